// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared definitions for the multi-channel click puzzle.
//   state_e  : puzzle FSM states
//   BLANK    : digit code that leaves a display digit dark
//   bin2bcd  : 8-bit binary to 3-digit BCD {hundreds, tens, ones}
package puzzle_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        PLAY = 3'd2,
        DONE = 3'd3,
        FAIL = 3'd4
    } state_e;

    localparam logic [3:0] BLANK = 4'hF;

    // Double-dabble: before each shift, any BCD digit >= 5 gets +3 so the
    // shift carries correctly into the next decimal digit.
    function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
        logic [19:0] s;
        s = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (s[11:8] >= 4'd5)  s[11:8]  = s[11:8]  + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = {s[18:0], 1'b0};
        end
        return s[19:8];
    endfunction

endpackage

// File: rtl/click_lfsr16.sv
// click_lfsr16: free-running 16-bit Fibonacci LFSR (taps 15,13,12,10),
// shifting left once per clock in every state.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, loads SEED
//   lfsr : current register value
module click_lfsr16 #(
    parameter logic [15:0] SEED = 16'hCAFE
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/phase1_multi_click.sv
// phase1_multi_click: multi-channel click puzzle. The player must reach a
// pseudo-random click target on each button in order 0..CHANNELS-1 before
// a seconds countdown runs out.
//   clk, rst    : clock / asynchronous active-high reset
//   enable      : puzzle active; low returns to IDLE on the next edge
//   btn         : debounced, clk-synchronous buttons
//   tick_1hz    : one-cycle strobe per second
//   seg_display : 8 digit codes, pairs {ones,tens}: cnt | ch+1 | time | target
//   motor_pulse : one-cycle pulse per accepted click
//   clear, fail : high while in DONE / FAIL
//   active_ch   : channel currently being played
module phase1_multi_click
    import puzzle_pkg::*;
#(
    parameter int          CHANNELS      = 2,
    parameter int          CNT_W         = 8,
    parameter int          TGT_BASE      = 20,
    parameter int          TGT_RAND_BITS = 5,
    parameter int          TIME_LIMIT    = 60,
    parameter int          STRICT        = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hCAFE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] btn,
    input  logic                tick_1hz,
    output logic [31:0]         seg_display,
    output logic                motor_pulse,
    output logic                clear,
    output logic                fail,
    output logic [1:0]          active_ch
);

    localparam int         CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [1:0] LAST_CH   = 2'(CHANNELS - 1);
    localparam logic [6:0] TIME_INIT = 7'(TIME_LIMIT);

    state_e             state_q, state_d;
    logic [1:0]         arm_idx_q, arm_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ch_q, ch_d;
    logic [6:0]         time_q, time_d;
    logic [CNT_W-1:0]   target_q [CHANNELS];
    logic [CNT_W-1:0]   target_d [CHANNELS];
    logic [CHANNELS-1:0] btn_q, btn_d;
    logic               motor_q, motor_d;
    logic               clear_q, clear_d;
    logic               fail_q, fail_d;

    logic [15:0]         lfsr;
    logic                lfsr_unused;
    logic [CNT_W-1:0]    rand_val;
    logic [CNT_W-1:0]    new_target;
    logic [CNT_W-1:0]    cur_target;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CHANNELS-1:0] click;
    logic [CHANNELS-1:0] correct_vec;
    logic [CHANNELS-1:0] wrong_vec;
    logic                correct_click;
    logic                wrong_click;
    logic                play_done;

    click_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Only the low TGT_RAND_BITS of the LFSR feed the target.
    assign lfsr_unused = ^lfsr;

    generate
        if (TGT_RAND_BITS == 0) begin : g_no_rand
            assign rand_val = '0;
        end else begin : g_rand
            assign rand_val = CNT_W'(lfsr[TGT_RAND_BITS-1:0]);
        end
    endgenerate

    assign new_target = CNT_W'(TGT_BASE) + rand_val;
    assign cur_target = target_q[ch_q[CH_W-1:0]];
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // Rising-edge detect: a held button produces a single click.
    assign btn_d = btn;
    assign click = btn & ~btn_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_click
            assign correct_vec[gi] = click[gi] & (ch_q == 2'(gi));
            assign wrong_vec[gi]   = click[gi] & (ch_q != 2'(gi));
        end
    endgenerate

    assign correct_click = |correct_vec;
    assign wrong_click   = |wrong_vec;

    always_comb begin
        state_d   = state_q;
        arm_idx_d = arm_idx_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        time_d    = time_q;
        target_d  = target_q;
        motor_d   = 1'b0;
        play_done = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                ch_d      = '0;
                time_d    = TIME_INIT;
                arm_idx_d = '0;
                if (enable) state_d = ARM;
            end
            ARM: begin
                // One target loaded per ARM cycle, channel k in cycle k.
                target_d[arm_idx_q[CH_W-1:0]] = new_target;
                if (arm_idx_q == LAST_CH) begin
                    state_d = PLAY;
                    ch_d    = '0;
                    cnt_d   = '0;
                end else begin
                    arm_idx_d = arm_idx_q + 2'd1;
                end
            end
            PLAY: begin
                if (tick_1hz) time_d = time_q - 7'd1;
                // In strict mode a wrong click overrides a simultaneous
                // correct one: reset, no pulse, no completion.
                if ((STRICT != 0) && wrong_click) begin
                    cnt_d = '0;
                end else if (correct_click) begin
                    motor_d = 1'b1;
                    if (cnt_inc == cur_target) begin
                        if (ch_q == LAST_CH) begin
                            play_done = 1'b1;
                            cnt_d     = cnt_inc;
                            state_d   = DONE;
                        end else begin
                            ch_d  = ch_q + 2'd1;
                            cnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                // Completion of the final channel beats the last tick.
                if (!play_done && tick_1hz && (time_q == 7'd1)) begin
                    state_d = FAIL;
                    time_d  = '0;
                end
            end
            DONE: begin
            end
            FAIL: begin
                time_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d   = IDLE;
            arm_idx_d = '0;
            cnt_d     = '0;
            ch_d      = '0;
            time_d    = TIME_INIT;
            motor_d   = 1'b0;
        end

        // Flags follow the next state so they are high for exactly the
        // cycles spent in DONE / FAIL.
        clear_d = (state_d == DONE);
        fail_d  = (state_d == FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            arm_idx_q <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            time_q    <= TIME_INIT;
            btn_q     <= '0;
            motor_q   <= 1'b0;
            clear_q   <= 1'b0;
            fail_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            arm_idx_q <= arm_idx_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            time_q    <= time_d;
            btn_q     <= btn_d;
            motor_q   <= motor_d;
            clear_q   <= clear_d;
            fail_q    <= fail_d;
            target_q  <= target_d;
        end
    end

    function automatic logic [7:0] bcd_pair(input logic [7:0] v);
        logic [11:0] bcd;
        bcd = bin2bcd(v);
        return {bcd[3:0], bcd[7:4]};
    endfunction

    logic [3:0] ch_ones;
    assign ch_ones = {2'b00, ch_q} + 4'd1;

    always_comb begin
        seg_display = {8{BLANK}};
        if ((state_q == PLAY) || (state_q == DONE) || (state_q == FAIL)) begin
            seg_display = {bcd_pair(8'(cnt_q)), ch_ones, BLANK,
                           bcd_pair(8'(time_q)), bcd_pair(8'(cur_target))};
        end
    end

    assign motor_pulse = motor_q;
    assign clear       = clear_q;
    assign fail        = fail_q;
    assign active_ch   = ch_q;

endmodule

// File: tb/tb_phase1_multi_click.sv
// tb_phase1_multi_click: drives two instances of phase1_multi_click.
//   u_dut_a : default parameters (seeded targets, 60 s countdown)
//   u_dut_b : fixed targets of 20, strict mode, 3 s countdown
module tb_phase1_multi_click;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, tick_a;
    logic [1:0]  btn_a;
    logic [31:0] seg_a;
    logic        motor_a, clear_a, fail_a;
    logic [1:0]  ch_a;

    logic        rst_b, en_b, tick_b;
    logic [1:0]  btn_b;
    logic [31:0] seg_b;
    logic        motor_b, clear_b, fail_b;
    logic [1:0]  ch_b;

    phase1_multi_click u_dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .enable      (en_a),
        .btn         (btn_a),
        .tick_1hz    (tick_a),
        .seg_display (seg_a),
        .motor_pulse (motor_a),
        .clear       (clear_a),
        .fail        (fail_a),
        .active_ch   (ch_a)
    );

    phase1_multi_click #(
        .TGT_RAND_BITS (0),
        .STRICT        (1),
        .TIME_LIMIT    (3)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .enable      (en_b),
        .btn         (btn_b),
        .tick_1hz    (tick_b),
        .seg_display (seg_b),
        .motor_pulse (motor_b),
        .clear       (clear_b),
        .fail        (fail_b),
        .active_ch   (ch_b)
    );

    int checks = 0;
    int errors = 0;
    int pulses_b = 0;

    always @(negedge clk) begin
        if (motor_b === 1'b1) pulses_b <= pulses_b + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Display pair {ones, tens} for a two-digit value.
    function automatic logic [7:0] pr(input int v);
        logic [3:0] o;
        logic [3:0] t;
        o = 4'(v % 10);
        t = 4'(v / 10);
        return {o, t};
    endfunction

    function automatic logic [31:0] disp(input int c, input int ch, input int tm, input int tg);
        logic [3:0] chd;
        chd = 4'(ch + 1);
        return {pr(c), chd, 4'hF, pr(tm), pr(tg)};
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    typedef struct {
        logic       en;
        logic [1:0] btn;
        logic       tick;
        logic       blank;
        int         cnt;
        int         ch;
        int         tm;
        logic       motor;
        logic       clr;
        logic       fl;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [1:0] b, input logic tk,
                                input logic bl, input int c, input int ch, input int tm,
                                input logic m, input logic cl, input logic fl);
        vec_t v;
        v.en = en; v.btn = b; v.tick = tk; v.blank = bl; v.cnt = c; v.ch = ch;
        v.tm = tm; v.motor = m; v.clr = cl; v.fl = fl;
        return v;
    endfunction

    task automatic press_b(input int c, input logic tk);
        btn_b[c] = 1'b1;
        tick_b   = tk;
        step();
        btn_b  = 2'b00;
        tick_b = 1'b0;
        step();
    endtask

    task automatic press_a(input int c);
        btn_a[c] = 1'b1;
        step();
        btn_a = 2'b00;
        step();
    endtask

    initial begin
        vec_t        tv[$];
        logic [31:0] exp_seg;
        logic [15:0] l1, l2;
        int          tgt0, tgt1, base;

        rst_a = 1'b0; en_a = 1'b0; btn_a = 2'b00; tick_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; btn_b = 2'b00; tick_b = 1'b0;
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        chk("reset_seg_a",   seg_a,   32'hFFFF_FFFF);
        chk("reset_motor_a", {31'd0, motor_a}, 32'd0);
        chk("reset_clear_a", {31'd0, clear_a}, 32'd0);
        chk("reset_fail_a",  {31'd0, fail_a},  32'd0);
        chk("reset_ch_a",    {30'd0, ch_a},    32'd0);
        chk("reset_seg_b",   seg_b,   32'hFFFF_FFFF);

        // ---- default instance: enable-to-PLAY latency and seeded targets
        l1   = lstep(16'hCAFE);
        l2   = lstep(l1);
        tgt0 = 20 + int'(l1[4:0]);
        tgt1 = 20 + int'(l2[4:0]);
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        en_a  = 1'b1;
        step();
        chk("arm0_blank_a", seg_a, 32'hFFFF_FFFF);
        step();
        chk("arm1_blank_a", seg_a, 32'hFFFF_FFFF);
        step();
        chk("play_entry_a", seg_a, disp(0, 0, 60, tgt0));
        $display("txn a: PLAY entered, target0=%0d target1=%0d", tgt0, tgt1);
        for (int i = 0; i < tgt0; i++) press_a(0);
        chk("ch1_target_a", seg_a, disp(0, 1, 60, tgt1));
        chk("ch1_index_a", {30'd0, ch_a}, 32'd1);
        en_a = 1'b0;
        step();
        chk("disable_blank_a", seg_a, 32'hFFFF_FFFF);

        // ---- table-driven run on the strict instance
        tv.push_back(mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            tv.push_back(mk(1, 2'b01, 0, 0, k, 0, 3, 1, 0, 0));
            tv.push_back(mk(1, 2'b00, 0, 0, k, 0, 3, 0, 0, 0));
        end
        tv.push_back(mk(1, 2'b10, 0, 0, 0, 0, 3, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0));
        tv.push_back(mk(1, 2'b01, 0, 0, 1, 0, 3, 1, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 0, 1, 0, 3, 0, 0, 0));
        tv.push_back(mk(1, 2'b11, 0, 0, 0, 0, 3, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0));
        tv.push_back(mk(1, 2'b01, 0, 0, 1, 0, 3, 1, 0, 0));
        tv.push_back(mk(1, 2'b01, 0, 0, 1, 0, 3, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 0, 1, 0, 3, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 1, 0, 1, 0, 2, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 0, 0, 1, 0, 2, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 2'b01, 1, 0, 1, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (tv[i]) begin
            en_b   = tv[i].en;
            btn_b  = tv[i].btn;
            tick_b = tv[i].tick;
            step();
            exp_seg = tv[i].blank ? 32'hFFFF_FFFF : disp(tv[i].cnt, tv[i].ch, tv[i].tm, 20);
            $display("vec %0d: en=%b btn=%b tick=%b seg=%08h motor=%b clear=%b fail=%b",
                     i, tv[i].en, tv[i].btn, tv[i].tick, seg_b, motor_b, clear_b, fail_b);
            chk($sformatf("vec%0d_seg", i),   seg_b,             exp_seg);
            chk($sformatf("vec%0d_motor", i), {31'd0, motor_b},  {31'd0, tv[i].motor});
            chk($sformatf("vec%0d_clear", i), {31'd0, clear_b},  {31'd0, tv[i].clr});
            chk($sformatf("vec%0d_fail", i),  {31'd0, fail_b},   {31'd0, tv[i].fl});
            chk($sformatf("vec%0d_ch", i),    {30'd0, ch_b},     32'(tv[i].ch));
        end
        btn_b  = 2'b00;
        tick_b = 1'b0;

        // ---- 20 + 20 clicks to clear, counting motor pulses
        en_b = 1'b1;
        step(); step(); step();
        chk("b_play_entry", seg_b, disp(0, 0, 3, 20));
        base = pulses_b;
        for (int i = 0; i < 19; i++) press_b(0, 1'b0);
        chk("b_cnt19", seg_b, disp(19, 0, 3, 20));
        btn_b[0] = 1'b1;
        step();
        chk("b_ch_advance", {30'd0, ch_b}, 32'd1);
        chk("b_ch_adv_motor", {31'd0, motor_b}, 32'd1);
        chk("b_ch_adv_seg", seg_b, disp(0, 1, 3, 20));
        btn_b = 2'b00;
        step();
        for (int i = 0; i < 19; i++) press_b(1, 1'b0);
        btn_b[1] = 1'b1;
        step();
        chk("b_clear", {31'd0, clear_b}, 32'd1);
        chk("b_done_seg", seg_b, disp(20, 1, 3, 20));
        btn_b = 2'b00;
        step();
        chk("b_pulses40", 32'(pulses_b - base), 32'd40);
        $display("txn b: cleared after %0d pulses", pulses_b - base);
        press_b(1, 1'b1);
        chk("b_done_hold_clear", {31'd0, clear_b}, 32'd1);
        chk("b_done_hold_seg", seg_b, disp(20, 1, 3, 20));
        chk("b_done_no_pulse", 32'(pulses_b - base), 32'd40);
        en_b = 1'b0;
        step();
        chk("b_idle_clear", {31'd0, clear_b}, 32'd0);
        chk("b_idle_seg", seg_b, 32'hFFFF_FFFF);

        // ---- final click coincides with the last tick: DONE wins
        en_b = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 2; i++) begin
            tick_b = 1'b1;
            step();
            tick_b = 1'b0;
            step();
        end
        chk("b_time1", seg_b, disp(0, 0, 1, 20));
        for (int i = 0; i < 20; i++) press_b(0, 1'b0);
        for (int i = 0; i < 19; i++) press_b(1, 1'b0);
        btn_b[1] = 1'b1;
        tick_b   = 1'b1;
        step();
        chk("race_clear", {31'd0, clear_b}, 32'd1);
        chk("race_fail",  {31'd0, fail_b},  32'd0);
        chk("race_seg",   seg_b, disp(20, 1, 0, 20));
        btn_b  = 2'b00;
        tick_b = 1'b0;
        step();
        chk("race_fail_later", {31'd0, fail_b}, 32'd0);
        $display("txn b: final click with last tick, clear=%b fail=%b", clear_b, fail_b);
        en_b = 1'b0;
        step();

        // ---- asynchronous reset in the middle of PLAY
        en_a = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 6; i++) press_a(0);
        btn_a[0] = 1'b1;
        step();
        chk("mid_cnt7", {24'd0, seg_a[31:24]}, {24'd0, pr(7)});
        chk("mid_motor", {31'd0, motor_a}, 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        chk("rst_now_seg",   seg_a,              32'hFFFF_FFFF);
        chk("rst_now_motor", {31'd0, motor_a},   32'd0);
        chk("rst_now_ch",    {30'd0, ch_a},      32'd0);
        chk("rst_now_flags", {30'd0, clear_a, fail_a}, 32'd0);
        btn_a = 2'b00;
        #3;
        rst_a = 1'b0;
        step();
        chk("rearm_blank", seg_a, 32'hFFFF_FFFF);
        step(); step();
        chk("reseed_target", seg_a, disp(0, 0, 60, tgt0));
        $display("txn a: reset mid-PLAY, re-entered PLAY seg=%08h", seg_a);
        en_a = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
